board_ctl: RTL and testbench
============================

BOARD_CTL -- requirements
Module: board_ctl

Interface
REQ-001 SHALL have ports: pclk  in  1  pixel clock, all logic on rising edge.
REQ-002 SHALL have: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have: mouse_xpos  in  12  cursor x, pixels, 1024x768 screen.
REQ-004 SHALL have: mouse_ypos  in  12  cursor y, pixels.
REQ-005 SHALL have: mouse_left  in  1  left button level, already synchronous to pclk.
REQ-006 SHALL have: new_game  in  1  level; clears board while high.
REQ-007 SHALL have: square_sel  out  9  one-hot highlight; bit k drives draw_squareK+1 squareK+1 input (bit 8 -> square9).
REQ-008 SHALL have: occupied  out  9  cell k holds a mark.
REQ-009 SHALL have: owner  out  9  mark of cell k: 0 = X, 1 = O; 0 when unoccupied.
REQ-010 SHALL have: turn  out  1  player to move: 0 = X, 1 = O.
REQ-011 SHALL have: winner  out  2  00 none, 01 X, 10 O, 11 draw.
REQ-012 SHALL have: game_over  out  1  high when winner != 00.

Function
REQ-013 SHALL register mouse_xpos, mouse_ypos, mouse_left once on input (stage 1); all decode uses registered values.
REQ-014 SHALL decode column: 0..340 -> 0, 341..684 -> 1, 685..1023 -> 2; row: 0..256 -> 0, 257..514 -> 1, 515..767 -> 2; x > 1023 or y > 767 -> no cell.
REQ-015 SHALL compute cell index k = 3*row + col (0..8) plus valid flag.
REQ-016 SHALL detect click as rising edge of registered mouse_left (current 1, previous 0); held button gives exactly one click.
REQ-017 SHALL run FSM states IDLE, PLACE, CHECK, DONE.
REQ-018 IDLE: click with valid cell and occupied[k] = 0 -> latch k, go PLACE; otherwise stay IDLE.
REQ-019 PLACE (one cycle): set occupied[k] = 1, owner[k] = turn, toggle turn, go CHECK.
REQ-020 CHECK (one cycle): evaluate 8 lines (3 rows, 3 columns, 2 diagonals) on updated board; line fully occupied with equal owners -> winner = 01/10 per owner, go DONE; else all 9 occupied -> winner = 11, go DONE; else go IDLE.
REQ-021 Clicks arriving in PLACE, CHECK or DONE SHALL be discarded, not queued.
REQ-022 DONE SHALL hold board, winner, game_over until new_game.
REQ-023 new_game high SHALL, from any state, on next edge clear occupied, owner, winner, set turn = 0, state IDLE; overrides a simultaneous click.
REQ-024 Latency: click edge on mouse_left -> occupied update visible 3 cycles later (input reg, IDLE decision, PLACE); winner/game_over 1 cycle after that.
REQ-025 game_over SHALL be registered, equal to (winner != 00).

Reset
REQ-026 rst SHALL set: state IDLE, occupied = 0, owner = 0, turn = 0, winner = 00, game_over = 0, square_sel = 0, all input registers and edge-detect history = 0.
REQ-027 rst SHALL take priority over new_game and clicks; reset mid-PLACE/CHECK leaves no partial update.

Configuration
REQ-028 Macro HOVER_HIGHLIGHT_EN defined: square_sel[k] SHALL be registered 1 when cursor is over cell k, cell k unoccupied and game_over = 0; else 0; latency 2 cycles from mouse_xpos/ypos.
REQ-029 Macro undefined: square_sel SHALL be constant 0; all other behaviour identical.

Structure
REQ-030 Shared package board_pkg SHALL hold column/row boundary constants (340, 684, 1023, 256, 514, 767), FSM state enum, winner encodings, 8-entry winning-line index table.
REQ-031 Sub-module cell_decode SHALL map (x, y) to (index 4 bit, valid); purely combinational, instantiated once.

Verification
REQ-032 Cursor (700, 600), click -> occupied = 9'h100, owner[8] = 0, turn = 1 after 3 cycles; with HOVER_HIGHLIGHT_EN, square_sel = 9'h100 before click, 0 after.
REQ-033 Boundaries: x = 340/341, 684/685, y = 256/257, 514/515 -> index changes exactly at 341, 685, 257, 515; (1024, 100) click -> no change.
REQ-034 X clicks cells 0,1,2 alternating with O on 3,4 -> winner = 01, game_over = 1; further click on cell 5 -> ignored.
REQ-035 Fill board with no line (X: 0,2,3,7,8; O: 1,4,5,6 in legal order) -> winner = 11 after ninth placement.
REQ-036 Click occupied cell, hold button 100 cycles, click during CHECK -> no state change beyond one placement.
REQ-037 new_game asserted same cycle as click, and rst mid-CHECK -> board cleared, turn = 0, winner = 00.

Source files
------------

// File: rtl/board_pkg.sv
// board_pkg: shared constants and types for the tic-tac-toe board controller.
// Screen partition bounds, FSM state encoding, winner encodings and the
// table of the eight winning lines (cell indices 0..8, row-major).
package board_pkg;

    // Inclusive upper bounds of each column / row on a 1024x768 screen.
    localparam logic [11:0] COL0_MAX = 12'd340;
    localparam logic [11:0] COL1_MAX = 12'd684;
    localparam logic [11:0] COL2_MAX = 12'd1023;
    localparam logic [11:0] ROW0_MAX = 12'd256;
    localparam logic [11:0] ROW1_MAX = 12'd514;
    localparam logic [11:0] ROW2_MAX = 12'd767;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLACE = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_X    = 2'b01;
    localparam logic [1:0] WIN_O    = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    localparam int NUM_LINES = 8;

    // Line L occupies WIN_LINES[L]; element order: rows 0-2, columns 0-2,
    // main diagonal, anti-diagonal (listed here from line 7 down to line 0).
    localparam logic [NUM_LINES-1:0][2:0][3:0] WIN_LINES = {
        {4'd2, 4'd4, 4'd6},
        {4'd0, 4'd4, 4'd8},
        {4'd2, 4'd5, 4'd8},
        {4'd1, 4'd4, 4'd7},
        {4'd0, 4'd3, 4'd6},
        {4'd6, 4'd7, 4'd8},
        {4'd3, 4'd4, 4'd5},
        {4'd0, 4'd1, 4'd2}
    };

endpackage

// File: rtl/cell_decode.sv
// cell_decode: maps a screen position to a board cell index (3*row + col)
// and a valid flag. Positions outside 1024x768 report no cell (index 0).
module cell_decode
    import board_pkg::*;
(
    input  logic [11:0] i_x,
    input  logic [11:0] i_y,
    output logic [3:0]  o_index,
    output logic        o_valid
);

    logic [1:0] w_col;
    logic [1:0] w_row;
    logic       w_col_ok;
    logic       w_row_ok;

    // Threshold compare on each axis, then combine into a cell index.
    always_comb begin
        w_col    = 2'd0;
        w_row    = 2'd0;
        w_col_ok = 1'b1;
        w_row_ok = 1'b1;

        if (i_x <= COL0_MAX)      w_col = 2'd0;
        else if (i_x <= COL1_MAX) w_col = 2'd1;
        else if (i_x <= COL2_MAX) w_col = 2'd2;
        else                      w_col_ok = 1'b0;

        if (i_y <= ROW0_MAX)      w_row = 2'd0;
        else if (i_y <= ROW1_MAX) w_row = 2'd1;
        else if (i_y <= ROW2_MAX) w_row = 2'd2;
        else                      w_row_ok = 1'b0;

        o_valid = w_col_ok & w_row_ok;
        o_index = o_valid ? (({2'b00, w_row} * 4'd3) + {2'b00, w_col}) : 4'd0;
    end

endmodule

// File: rtl/board_ctl.sv
// board_ctl: tic-tac-toe game controller driven by a mouse cursor.
// Inputs are registered once, a rising edge of the button is a click, and a
// four-state FSM (IDLE/PLACE/CHECK/DONE) places marks and scores the board.
// Optional feature: define HOVER_HIGHLIGHT_EN to drive square_sel with the
// free cell under the cursor; otherwise square_sel is tied to zero.
module board_ctl
    import board_pkg::*;
(
    input  logic        pclk,
    input  logic        rst,
    input  logic [11:0] mouse_xpos,
    input  logic [11:0] mouse_ypos,
    input  logic        mouse_left,
    input  logic        new_game,
    output logic [8:0]  square_sel,
    output logic [8:0]  occupied,
    output logic [8:0]  owner,
    output logic        turn,
    output logic [1:0]  winner,
    output logic        game_over
);

    logic [11:0] r_xpos;
    logic [11:0] r_ypos;
    logic        r_left;
    logic        r_left_prev;

    state_t      r_state;
    state_t      w_state_next;

    logic [3:0]  r_cell;
    logic [8:0]  r_occupied;
    logic [8:0]  r_owner;
    logic        r_turn;
    logic [1:0]  r_winner;
    logic        r_game_over;

    logic [3:0]  w_index;
    logic        w_valid;
    logic        w_click;
    logic        w_accept;

    logic [NUM_LINES-1:0] w_line_x;
    logic [NUM_LINES-1:0] w_line_o;
    logic [1:0]           w_winner_eval;

    // Stage 1: capture cursor and button; keep one cycle of button history.
    always_ff @(posedge pclk) begin
        if (rst) begin
            r_xpos      <= 12'd0;
            r_ypos      <= 12'd0;
            r_left      <= 1'b0;
            r_left_prev <= 1'b0;
        end else begin
            r_xpos      <= mouse_xpos;
            r_ypos      <= mouse_ypos;
            r_left      <= mouse_left;
            r_left_prev <= r_left;
        end
    end

    cell_decode u_cell_decode (
        .i_x     (r_xpos),
        .i_y     (r_ypos),
        .o_index (w_index),
        .o_valid (w_valid)
    );

    assign w_click  = r_left & ~r_left_prev;
    assign w_accept = w_click & w_valid & ~r_occupied[w_index];

    // One evaluator per winning line: fully occupied with all-X or all-O.
    for (genvar gi = 0; gi < NUM_LINES; gi++) begin : g_line
        localparam logic [3:0] A = WIN_LINES[gi][0];
        localparam logic [3:0] B = WIN_LINES[gi][1];
        localparam logic [3:0] C = WIN_LINES[gi][2];
        logic w_full;
        assign w_full       = r_occupied[A] & r_occupied[B] & r_occupied[C];
        assign w_line_x[gi] = w_full & ~(r_owner[A] | r_owner[B] | r_owner[C]);
        assign w_line_o[gi] = w_full & r_owner[A] & r_owner[B] & r_owner[C];
    end

    // Score the current board: a completed line wins, a full board draws.
    always_comb begin
        w_winner_eval = WIN_NONE;
        if (|w_line_x)          w_winner_eval = WIN_X;
        else if (|w_line_o)     w_winner_eval = WIN_O;
        else if (&r_occupied)   w_winner_eval = WIN_DRAW;
    end

    // FSM state register.
    always_ff @(posedge pclk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    // FSM next-state: new_game wins over everything; clicks only count in IDLE.
    always_comb begin
        w_state_next = r_state;
        if (new_game) begin
            w_state_next = ST_IDLE;
        end else begin
            unique case (r_state)
                ST_IDLE:  if (w_accept) w_state_next = ST_PLACE;
                ST_PLACE: w_state_next = ST_CHECK;
                ST_CHECK: w_state_next = (w_winner_eval != WIN_NONE) ? ST_DONE : ST_IDLE;
                ST_DONE:  w_state_next = ST_DONE;
                default:  w_state_next = ST_IDLE;
            endcase
        end
    end

    // Board, turn and result registers, updated in step with the FSM.
    always_ff @(posedge pclk) begin
        if (rst || new_game) begin
            r_cell      <= 4'd0;
            r_occupied  <= 9'd0;
            r_owner     <= 9'd0;
            r_turn      <= 1'b0;
            r_winner    <= WIN_NONE;
            r_game_over <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_accept) r_cell <= w_index;
                end
                ST_PLACE: begin
                    r_occupied[r_cell] <= 1'b1;
                    r_owner[r_cell]    <= r_turn;
                    r_turn             <= ~r_turn;
                end
                ST_CHECK: begin
                    r_winner    <= w_winner_eval;
                    r_game_over <= (w_winner_eval != WIN_NONE);
                end
                default: begin
                end
            endcase
        end
    end

`ifdef HOVER_HIGHLIGHT_EN
    logic [8:0] r_square_sel;

    // Highlight the free cell under the cursor while the game is live.
    always_ff @(posedge pclk) begin
        if (rst) begin
            r_square_sel <= 9'd0;
        end else if (w_valid && !r_game_over) begin
            r_square_sel <= (9'd1 << w_index) & ~r_occupied;
        end else begin
            r_square_sel <= 9'd0;
        end
    end

    assign square_sel = r_square_sel;
`else
    assign square_sel = 9'd0;
`endif

    assign occupied  = r_occupied;
    assign owner     = r_owner;
    assign turn      = r_turn;
    assign winner    = r_winner;
    assign game_over = r_game_over;

endmodule

// File: tb/tb_board_ctl.sv
// tb_board_ctl: scoreboard bench for board_ctl. Each click pushes the board
// state a reference model predicts; the test task pops and compares it once
// the DUT has had time to place and score the move.
module tb_board_ctl;

    logic        pclk = 1'b0;
    logic        rst;
    logic [11:0] mouse_xpos;
    logic [11:0] mouse_ypos;
    logic        mouse_left;
    logic        new_game;
    logic [8:0]  square_sel;
    logic [8:0]  occupied;
    logic [8:0]  owner;
    logic        turn;
    logic [1:0]  winner;
    logic        game_over;

    always #5 pclk = ~pclk;

    board_ctl dut (
        .pclk       (pclk),
        .rst        (rst),
        .mouse_xpos (mouse_xpos),
        .mouse_ypos (mouse_ypos),
        .mouse_left (mouse_left),
        .new_game   (new_game),
        .square_sel (square_sel),
        .occupied   (occupied),
        .owner      (owner),
        .turn       (turn),
        .winner     (winner),
        .game_over  (game_over)
    );

    typedef struct {
        logic [8:0] occ;
        logic [8:0] own;
        logic       trn;
        logic [1:0] win;
    } exp_t;

    exp_t sb_q[$];
    exp_t e;

    int n_checks = 0;
    int n_pass   = 0;

    logic [8:0] m_occ;
    logic [8:0] m_own;
    logic       m_turn;
    logic [1:0] m_win;
    logic [8:0] hover_exp;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge pclk);
            #1;
        end
    endtask

    function automatic int cx(input int k);
        return (k % 3 == 0) ? 170 : ((k % 3 == 1) ? 512 : 850);
    endfunction

    function automatic int cy(input int k);
        return (k / 3 == 0) ? 128 : ((k / 3 == 1) ? 384 : 640);
    endfunction

    function automatic int bench_cell(input int x, input int y);
        int c;
        int r;
        if (x < 0 || x > 1023 || y < 0 || y > 767) return -1;
        c = (x <= 340) ? 0 : ((x <= 684) ? 1 : 2);
        r = (y <= 256) ? 0 : ((y <= 514) ? 1 : 2);
        return 3 * r + c;
    endfunction

    function automatic logic [1:0] eval_model();
        int ln [8][3];
        ln = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
               '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
        for (int i = 0; i < 8; i++) begin
            if (m_occ[ln[i][0]] && m_occ[ln[i][1]] && m_occ[ln[i][2]]) begin
                if (!m_own[ln[i][0]] && !m_own[ln[i][1]] && !m_own[ln[i][2]]) return 2'b01;
                if (m_own[ln[i][0]] && m_own[ln[i][1]] && m_own[ln[i][2]]) return 2'b10;
            end
        end
        if (m_occ == 9'h1FF) return 2'b11;
        return 2'b00;
    endfunction

    task automatic model_reset();
        m_occ  = 9'd0;
        m_own  = 9'd0;
        m_turn = 1'b0;
        m_win  = 2'b00;
    endtask

    task automatic push_model();
        sb_q.push_back('{occ: m_occ, own: m_own, trn: m_turn, win: m_win});
    endtask

    // Predict the effect of one click, then queue the expected board.
    task automatic model_click(input int x, input int y);
        int k;
        k = bench_cell(x, y);
        if (m_win == 2'b00 && k >= 0 && !m_occ[k]) begin
            m_occ[k] = 1'b1;
            m_own[k] = m_turn;
            m_turn   = ~m_turn;
            m_win    = eval_model();
        end
        push_model();
    endtask

    task automatic drive_click(input int x, input int y);
        mouse_xpos = 12'(x);
        mouse_ypos = 12'(y);
        mouse_left = 1'b0;
        tick(2);
        mouse_left = 1'b1;
        model_click(x, y);
        tick(5);
        mouse_left = 1'b0;
        tick(1);
    endtask

    task automatic do_new_game();
        new_game = 1'b1;
        tick(1);
        new_game = 1'b0;
        tick(1);
        model_reset();
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        new_game   = 1'b1;
        mouse_left = 1'b1;
        mouse_xpos = 12'd512;
        mouse_ypos = 12'd384;
        tick(3);
        rst        = 1'b0;
        new_game   = 1'b0;
        mouse_left = 1'b0;
        model_reset();
        #0;
        n_checks++;
        if ({occupied, owner, turn, winner, game_over, square_sel} !== 31'd0)
            $display("FAIL reset: occ=%h own=%h turn=%b win=%b go=%b sel=%h, expected all zero",
                     occupied, owner, turn, winner, game_over, square_sel);
        else begin
            n_pass++;
            $display("ok   reset: outputs zero");
        end
        tick(1);
    endtask

    task automatic test_first_click();
        mouse_xpos = 12'd700;
        mouse_ypos = 12'd600;
        mouse_left = 1'b0;
        tick(2);
`ifdef HOVER_HIGHLIGHT_EN
        hover_exp = 9'h100;
`else
        hover_exp = 9'h000;
`endif
        n_checks++;
        if (square_sel !== hover_exp)
            $display("FAIL hover_before: square_sel=%h expected %h", square_sel, hover_exp);
        else begin n_pass++; $display("ok   hover_before: square_sel=%h", square_sel); end

        mouse_left = 1'b1;
        model_click(700, 600);
        tick(2);
        n_checks++;
        if (occupied !== 9'h000)
            $display("FAIL latency_early: occupied=%h expected 000 two cycles after press", occupied);
        else begin n_pass++; $display("ok   latency_early: occupied=000"); end

        tick(1);
        n_checks++;
        if (occupied !== 9'h100 || owner !== 9'h000 || turn !== 1'b1)
            $display("FAIL latency_place: occ=%h own=%h turn=%b expected occ=100 own=000 turn=1",
                     occupied, owner, turn);
        else begin n_pass++; $display("ok   latency_place: occ=100 turn=1"); end

        tick(1);
        e = sb_q.pop_front();
        n_checks++;
        if (occupied !== e.occ || owner !== e.own || turn !== e.trn || winner !== e.win || game_over !== (e.win != 2'b00))
            $display("FAIL first_click: occ=%h own=%h turn=%b win=%b go=%b expected occ=%h own=%h turn=%b win=%b",
                     occupied, owner, turn, winner, game_over, e.occ, e.own, e.trn, e.win);
        else begin n_pass++; $display("ok   first_click: occ=%h win=%b", occupied, winner); end

        mouse_left = 1'b0;
        tick(1);
        n_checks++;
        if (square_sel !== 9'h000)
            $display("FAIL hover_after: square_sel=%h expected 000", square_sel);
        else begin n_pass++; $display("ok   hover_after: square_sel=000"); end
    endtask

    task automatic test_boundary();
        int bx [11];
        int by [11];
        bx = '{340, 341, 684, 685, 100, 100, 100, 100, 1024, 100, 1023};
        by = '{100, 100, 100, 100, 256, 257, 514, 515, 100, 768, 767};
        for (int i = 0; i < 11; i++) begin
            do_new_game();
            drive_click(bx[i], by[i]);
            e = sb_q.pop_front();
            n_checks++;
            if (occupied !== e.occ || owner !== e.own || turn !== e.trn || winner !== e.win || game_over !== (e.win != 2'b00))
                $display("FAIL boundary(%0d,%0d): occ=%h turn=%b win=%b expected occ=%h turn=%b win=%b",
                         bx[i], by[i], occupied, turn, winner, e.occ, e.trn, e.win);
            else begin n_pass++; $display("ok   boundary(%0d,%0d): occ=%h", bx[i], by[i], occupied); end
        end
    endtask

    task automatic test_win();
        int seq [6];
        seq = '{0, 3, 1, 4, 2, 5};
        do_new_game();
        for (int i = 0; i < 6; i++) begin
            drive_click(cx(seq[i]), cy(seq[i]));
            e = sb_q.pop_front();
            n_checks++;
            if (occupied !== e.occ || owner !== e.own || turn !== e.trn || winner !== e.win || game_over !== (e.win != 2'b00))
                $display("FAIL win_cell%0d: occ=%h own=%h turn=%b win=%b go=%b expected occ=%h own=%h turn=%b win=%b",
                         seq[i], occupied, owner, turn, winner, game_over, e.occ, e.own, e.trn, e.win);
            else begin n_pass++; $display("ok   win_cell%0d: occ=%h win=%b", seq[i], occupied, winner); end
        end
        n_checks++;
        if (winner !== 2'b01 || game_over !== 1'b1)
            $display("FAIL win_result: winner=%b go=%b expected 01/1", winner, game_over);
        else begin n_pass++; $display("ok   win_result: X wins"); end

        mouse_xpos = 12'(cx(7));
        mouse_ypos = 12'(cy(7));
        tick(3);
        n_checks++;
        if (square_sel !== 9'h000)
            $display("FAIL hover_gameover: square_sel=%h expected 000", square_sel);
        else begin n_pass++; $display("ok   hover_gameover: square_sel=000"); end
    endtask

    task automatic test_draw();
        int seq [9];
        seq = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
        do_new_game();
        for (int i = 0; i < 9; i++) begin
            drive_click(cx(seq[i]), cy(seq[i]));
            e = sb_q.pop_front();
            n_checks++;
            if (occupied !== e.occ || owner !== e.own || turn !== e.trn || winner !== e.win || game_over !== (e.win != 2'b00))
                $display("FAIL draw_cell%0d: occ=%h own=%h turn=%b win=%b expected occ=%h own=%h turn=%b win=%b",
                         seq[i], occupied, owner, turn, winner, e.occ, e.own, e.trn, e.win);
            else begin n_pass++; $display("ok   draw_cell%0d: occ=%h win=%b", seq[i], occupied, winner); end
        end
        n_checks++;
        if (winner !== 2'b11 || game_over !== 1'b1)
            $display("FAIL draw_result: winner=%b go=%b expected 11/1", winner, game_over);
        else begin n_pass++; $display("ok   draw_result: draw"); end
    endtask

    task automatic test_held_and_check();
        do_new_game();
        drive_click(cx(4), cy(4));
        void'(sb_q.pop_front());

        // Re-click the occupied centre and hold it.
        mouse_xpos = 12'(cx(4));
        mouse_ypos = 12'(cy(4));
        mouse_left = 1'b0;
        tick(2);
        mouse_left = 1'b1;
        model_click(cx(4), cy(4));
        tick(100);
        mouse_left = 1'b0;
        tick(1);
        e = sb_q.pop_front();
        n_checks++;
        if (occupied !== e.occ || owner !== e.own || turn !== e.trn || winner !== e.win)
            $display("FAIL occupied_click: occ=%h own=%h turn=%b expected occ=%h own=%h turn=%b",
                     occupied, owner, turn, e.occ, e.own, e.trn);
        else begin n_pass++; $display("ok   occupied_click: occ=%h", occupied); end

        // Hold a free cell for 100 cycles: exactly one placement.
        mouse_xpos = 12'(cx(0));
        mouse_ypos = 12'(cy(0));
        tick(2);
        mouse_left = 1'b1;
        model_click(cx(0), cy(0));
        tick(100);
        mouse_left = 1'b0;
        tick(1);
        e = sb_q.pop_front();
        n_checks++;
        if (occupied !== e.occ || owner !== e.own || turn !== e.trn || winner !== e.win)
            $display("FAIL held_button: occ=%h own=%h turn=%b expected occ=%h own=%h turn=%b",
                     occupied, owner, turn, e.occ, e.own, e.trn);
        else begin n_pass++; $display("ok   held_button: occ=%h", occupied); end

        // Second press lands on a free cell while the FSM is in CHECK.
        mouse_xpos = 12'(cx(1));
        mouse_ypos = 12'(cy(1));
        tick(2);
        mouse_left = 1'b1;
        model_click(cx(1), cy(1));
        tick(1);
        mouse_left = 1'b0;
        tick(1);
        mouse_xpos = 12'(cx(2));
        mouse_ypos = 12'(cy(2));
        mouse_left = 1'b1;
        tick(5);
        mouse_left = 1'b0;
        tick(1);
        e = sb_q.pop_front();
        n_checks++;
        if (occupied !== e.occ || owner !== e.own || turn !== e.trn || winner !== e.win)
            $display("FAIL click_in_check: occ=%h own=%h turn=%b expected occ=%h own=%h turn=%b",
                     occupied, owner, turn, e.occ, e.own, e.trn);
        else begin n_pass++; $display("ok   click_in_check: occ=%h", occupied); end
    endtask

    task automatic test_newgame_click();
        mouse_xpos = 12'(cx(8));
        mouse_ypos = 12'(cy(8));
        mouse_left = 1'b0;
        tick(2);
        mouse_left = 1'b1;
        tick(1);
        new_game = 1'b1;
        tick(1);
        new_game = 1'b0;
        tick(4);
        mouse_left = 1'b0;
        tick(1);
        model_reset();
        push_model();
        e = sb_q.pop_front();
        n_checks++;
        if (occupied !== e.occ || owner !== e.own || turn !== e.trn || winner !== e.win || game_over !== 1'b0)
            $display("FAIL newgame_with_click: occ=%h turn=%b win=%b go=%b expected cleared board",
                     occupied, turn, winner, game_over);
        else begin n_pass++; $display("ok   newgame_with_click: board cleared"); end

        drive_click(cx(8), cy(8));
        e = sb_q.pop_front();
        n_checks++;
        if (occupied !== e.occ || owner !== e.own || turn !== e.trn || winner !== e.win)
            $display("FAIL after_newgame: occ=%h own=%h turn=%b expected occ=%h own=%h turn=%b",
                     occupied, owner, turn, e.occ, e.own, e.trn);
        else begin n_pass++; $display("ok   after_newgame: occ=%h", occupied); end
    endtask

    task automatic test_reset_mid_check();
        mouse_xpos = 12'(cx(1));
        mouse_ypos = 12'(cy(1));
        mouse_left = 1'b0;
        tick(2);
        mouse_left = 1'b1;
        tick(3);
        rst = 1'b1;
        tick(1);
        rst        = 1'b0;
        mouse_left = 1'b0;
        tick(2);
        model_reset();
        push_model();
        e = sb_q.pop_front();
        n_checks++;
        if (occupied !== e.occ || owner !== e.own || turn !== e.trn || winner !== e.win || game_over !== 1'b0)
            $display("FAIL reset_mid_check: occ=%h own=%h turn=%b win=%b expected cleared board",
                     occupied, owner, turn, winner);
        else begin n_pass++; $display("ok   reset_mid_check: board cleared"); end

        drive_click(cx(2), cy(2));
        e = sb_q.pop_front();
        n_checks++;
        if (occupied !== e.occ || owner !== e.own || turn !== e.trn || winner !== e.win)
            $display("FAIL after_reset: occ=%h own=%h turn=%b expected occ=%h own=%h turn=%b",
                     occupied, owner, turn, e.occ, e.own, e.trn);
        else begin n_pass++; $display("ok   after_reset: occ=%h", occupied); end
    endtask

    initial begin
        rst        = 1'b1;
        new_game   = 1'b0;
        mouse_left = 1'b0;
        mouse_xpos = 12'd0;
        mouse_ypos = 12'd0;
        model_reset();
        test_reset();
        test_first_click();
        test_boundary();
        test_win();
        test_draw();
        test_held_and_check();
        test_newgame_click();
        test_reset_mid_check();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
